cpu_axi_master: RTL

Single-beat AXI4 master bridge between the CPU core's instruction or data memory port and the AXI interconnect. One instance is used per core port; its AR/R/AW/W/B channels feed the interconnect master slot, which routes to the SRAM wrapper slaves. It converts a simple stall-based core request into one sequential AXI read or write transaction and holds the core stalled until the response returns.

---
 rtl/cpu_axi_master_pkg.sv | 8 +
 rtl/cpu_axi_master.sv | 111 +++++++++++
 2 files changed

// File: rtl/cpu_axi_master_pkg.sv
// cpu_axi_master_pkg: FSM state type and fixed AXI field values for the single-beat master bridge
package cpu_axi_master_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_ONE    = 4'd0;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
endpackage

// File: rtl/cpu_axi_master.sv
// cpu_axi_master: turns a stall-based core memory request into one single-beat AXI4 read or write
// Ports: CLK/RST (async, active-high); core_req/we/addr/wdata/web in, core_stall/rdata/err out;
//        AXI4 master AW/W/B/AR/R channels toward the interconnect (RID/BID ignored).
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_web,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);
    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  web_q;
    logic        r_done, b_done, done, unused;
    assign unused = ^{RID, BID};
    // READY is held high for the whole R/B state, so a VALID there is the handshake
    assign r_done = state == S_R && RVALID && RLAST;
    assign b_done = state == S_B && BVALID;
    assign done   = r_done | b_done;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            web_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state == S_IDLE && core_req) begin
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
                web_q   <= core_web;
            end
            if (r_done) rdata_q <= RDATA;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (core_req) state_n = core_we ? S_AW : S_AR;
            S_AR:    if (ARREADY)  state_n = S_R;
            S_R:     if (r_done)   state_n = S_IDLE;
            S_AW:    if (AWREADY)  state_n = S_W;
            S_W:     if (WREADY)   state_n = S_B;
            S_B:     if (b_done)   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    assign ARVALID = state == S_AR;
    assign RREADY  = state == S_R;
    assign AWVALID = state == S_AW;
    assign WVALID  = state == S_W;
    assign BREADY  = state == S_B;
    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = AXI_LEN_ONE;
    assign ARSIZE  = AXI_SIZE_WORD;
    assign ARBURST = AXI_BURST_INCR;
    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = AXI_LEN_ONE;
    assign AWSIZE  = AXI_SIZE_WORD;
    assign AWBURST = AXI_BURST_INCR;
    assign WDATA   = wdata_q;
    assign WSTRB   = web_q;
    assign WLAST   = 1'b1;
    // completion is visible to the core in the same cycle the response arrives
    assign core_stall = (state == S_IDLE) ? core_req : ~done;
    assign core_rdata = r_done ? RDATA : rdata_q;
    assign core_err   = (r_done && RRESP != RESP_OKAY) || (b_done && BRESP != RESP_OKAY);
endmodule
